alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

EX-stage execution unit consuming the 3-bit ALU control code produced by ALU control decode, together with the two forwarded operands. Single-cycle ops (ADD/SUB/AND/XOR/SLL/SRA/NOP) have a registered result with 1-cycle latency. MUL is computed by an iterative shift-add multiplier. While MUL runs, the unit asserts a stall to the hazard unit so IF/ID/EX hold their contents.

## Interface
- XLEN, 32, operand/result width
- MUL_STEP, 1, multiplier bits retired per iteration; legal values 1, 2, 4; MUL_ITERS = XLEN/MUL_STEP
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset; one clock, reset is synchronous and active-low
- valid_i  input  1  operation present on ALUCtrl_i/data1_i/data2_i
- ALUCtrl_i  input  3  000 ADD, 001 SUB, 010 MUL, 011 NOP, 100 AND, 101 XOR, 110 SLL, 111 SRA
- data1_i  input  XLEN  operand rs1
- data2_i  input  XLEN  operand rs2 / immediate
- flush_i  input  1  discard in-flight op (branch mispredict)
- ready_o  output  1  unit can accept an op this cycle (state IDLE)
- stall_o  output  1  MUL in progress; equals !ready_o
- valid_o  output  1  one-cycle pulse: data_o/zero_o updated this cycle
- data_o  output  XLEN  result, held until next result
- zero_o  output  1  data_o == 0, registered with data_o

## Operation
- States: IDLE, MUL. Iteration counter width clog2(MUL_ITERS)+1. Registers: multiplicand, multiplier shift register, accumulator.
- Accept = valid_i && ready_o && !flush_i.
- IDLE, accept, non-MUL: compute the result, register it into data_o/zero_o, set valid_o=1, and stay in IDLE.
  - ADD/SUB wrap modulo 2^XLEN.
  - AND and XOR are bitwise.
  - SLL shifts data1_i left by data2_i[4:0].
  - SRA shifts data1_i arithmetically right by data2_i[4:0], with sign fill.
  - NOP: data_o=0, zero_o=1.
- IDLE, accept, MUL: latch data1_i into multiplicand, data2_i into the multiplier register. Clear the accumulator and counter. Go to MUL with valid_o=0.
- MUL, each edge:
  - Add multiplicand × (low MUL_STEP bits of multiplier) into the accumulator.
  - Shift the multiplicand left by MUL_STEP and the multiplier right by MUL_STEP.
  - Increment the counter.
- On the edge completing iteration MUL_ITERS: data_o = low XLEN bits of the accumulator result, zero_o updated, valid_o=1, go to IDLE.
- Result is the low XLEN bits of the product, identical for signed and unsigned operands.
- In MUL, valid_i and operand inputs are ignored. Upstream holds them because stall_o=1.
- flush_i has priority over valid_i and over MUL iterations. On the flush edge: state → IDLE, counter cleared, valid_o=0, data_o/zero_o unchanged, and no op is accepted that cycle.
- Reset (rst_i=0 at an edge) overrides everything, including a MUL in progress. After reset: state IDLE, ready_o=1, stall_o=0, valid_o=0, data_o=0, zero_o=0, counter=0, accumulator=0.

## Timing
- Non-MUL: accepted at edge E0; valid_o high during the cycle after E0 (latency 1). Back-to-back accepts every cycle are allowed.
- MUL: accepted at E0. ready_o=0 and stall_o=1 from just after E0 through the cycle before E_MUL_ITERS. Result and valid_o appear after edge E_MUL_ITERS, so latency is MUL_ITERS cycles (32 at default).
- In the valid_o cycle after a MUL, state is IDLE and ready_o=1, so a new op can be accepted on that same cycle's edge.
- valid_o is exactly one cycle wide per accepted op. There is no downstream backpressure.
- ready_o and stall_o are decoded from state register outputs only, with no combinational path from valid_i or ALUCtrl_i.
- A flush on the same edge as the final MUL iteration wins: no valid_o, result discarded.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 0x00000001 → next cycle valid_o=1, data_o=0x80000000, zero_o=0. Then SUB 0 - 1 → data_o=0xFFFFFFFF.
- MUL 7 × 6 → stall_o=1 and ready_o=0 for exactly 32 cycles; valid_o pulses once with data_o=42. Then MUL 0xFFFFFFFF × 0xFFFFFFFF → data_o=0x00000001.
- SRA 0x80000000 by 4 → 0xF8000000. SLL 0x00000001 by 31 → 0x80000000. AND 0xF0F0 & 0x0F0F → 0, zero_o=1. NOP → data_o=0, zero_o=1.
- flush_i asserted 10 cycles into MUL 3 × 5 → next cycle state IDLE, ready_o=1, no valid_o, data_o keeps its previous value. A subsequent ADD 2+2 → 4.
- rst_i=0 mid-MUL → after the edge all outputs at reset values. Then ADD 1+1 → 2 with 1-cycle latency.
- MUL 2 × 3 immediately followed by ADD 1+1, accepted in the valid_o cycle → results 6, then 2 on consecutive valid_o pulses. Repeat with MUL_STEP=4 and confirm 8-cycle MUL latency.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage execution unit.
//   Single-cycle ops (ADD/SUB/AND/XOR/SLL/SRA/NOP) give a registered result one cycle
//   after acceptance. MUL runs on an iterative shift-add multiplier that retires MUL_STEP
//   multiplier bits per cycle. stall_o holds the upstream pipeline while it runs.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-low reset
//   valid_i    operation present on ALUCtrl_i/data1_i/data2_i
//   ALUCtrl_i  op code: 000 ADD, 001 SUB, 010 MUL, 011 NOP, 100 AND, 101 XOR, 110 SLL, 111 SRA
//   data1_i    operand rs1
//   data2_i    operand rs2 / immediate
//   flush_i    discard in-flight op, accept nothing this cycle
//   ready_o    unit idle, can accept an op
//   stall_o    MUL in progress (== !ready_o)
//   valid_o    one-cycle pulse: data_o/zero_o updated
//   data_o     result, held until next result
//   zero_o     data_o == 0
module alu_exec_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      ALUCtrl_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o,
  output logic            zero_o
);

  localparam int unsigned MulIters = XLEN / MUL_STEP;
  localparam int unsigned CntW     = $clog2(MulIters) + 1;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpNop = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpXor = 3'b101;
  localparam logic [2:0] OpSll = 3'b110;
  localparam logic [2:0] OpSra = 3'b111;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            zero_q, zero_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] step_sum;

  // Single-cycle datapath
  always_comb begin
    alu_res = '0;
    unique case (ALUCtrl_i)
      OpAdd:   alu_res = data1_i + data2_i;
      OpSub:   alu_res = data1_i - data2_i;
      OpAnd:   alu_res = data1_i & data2_i;
      OpXor:   alu_res = data1_i ^ data2_i;
      OpSll:   alu_res = data1_i << data2_i[4:0];
      OpSra:   alu_res = $signed(data1_i) >>> data2_i[4:0];
      OpNop:   alu_res = '0;
      OpMul:   alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // One multiplier iteration: accumulate multiplicand x low MUL_STEP multiplier bits.
  // Only the low XLEN bits of the product are kept, so signedness does not matter.
  always_comb begin
    step_sum = acc_q;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) begin
        step_sum = step_sum + (mcand_q << i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    data_d   = data_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;

    if (flush_i) begin
      // Flush beats both a new accept and a MUL iteration, including the last one.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            if (ALUCtrl_i == OpMul) begin
              state_d  = StMul;
              mcand_d  = data1_i;
              mplier_d = data2_i;
              acc_d    = '0;
              cnt_d    = '0;
            end else begin
              data_d  = alu_res;
              zero_d  = (alu_res == '0);
              valid_d = 1'b1;
            end
          end
        end
        StMul: begin
          acc_d    = step_sum;
          mcand_d  = mcand_q << MUL_STEP;
          mplier_d = mplier_q >> MUL_STEP;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntW'(MulIters - 1)) begin
            state_d = StIdle;
            data_d  = step_sum;
            zero_d  = (step_sum == '0);
            valid_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign stall_o = (state_q != StIdle);
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  // default instance (MUL_STEP=1)
  logic        valid, flush;
  logic [2:0]  ctrl;
  logic [31:0] d1, d2;
  logic        ready, stall, vout, zero;
  logic [31:0] dout;
  // MUL_STEP=4 instance
  logic        valid4, flush4;
  logic [2:0]  ctrl4;
  logic [31:0] d14, d24;
  logic        ready4, stall4, vout4, zero4;
  logic [31:0] dout4;

  int checks = 0;
  int errors = 0;
  int n;
  int nv;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .MUL_STEP(1)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ALUCtrl_i(ctrl), .data1_i(d1),
    .data2_i(d2), .flush_i(flush), .ready_o(ready), .stall_o(stall), .valid_o(vout),
    .data_o(dout), .zero_o(zero)
  );

  alu_exec_unit #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid4), .ALUCtrl_i(ctrl4), .data1_i(d14),
    .data2_i(d24), .flush_i(flush4), .ready_o(ready4), .stall_o(stall4), .valid_o(vout4),
    .data_o(dout4), .zero_o(zero4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1;
    ctrl  = c;
    d1    = a;
    d2    = b;
  endtask

  // Accept a MUL on the default instance; count stall cycles and stray valid pulses.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    op(3'b010, a, b);
    tick();
    valid = 1'b0;
    n  = 0;
    nv = 0;
    while (stall && n < 100) begin
      n++;
      if (vout) nv++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ctrl = 3'b011; d1 = '0; d2 = '0;
    valid4 = 1'b0; flush4 = 1'b0; ctrl4 = 3'b011; d14 = '0; d24 = '0;
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(vout), 32'd0);
    chk("rst_data", dout, 32'h0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst4_ready", 32'(ready4), 32'd1);
    rst_n = 1'b1;
    tick();

    // ADD overflow wraps, then back-to-back SUB
    op(3'b000, 32'h7FFF_FFFF, 32'h1);
    tick();
    chk("add_valid", 32'(vout), 32'd1);
    chk("add_data", dout, 32'h8000_0000);
    chk("add_zero", 32'(zero), 32'd0);
    op(3'b001, 32'h0, 32'h1);
    tick();
    chk("sub_valid", 32'(vout), 32'd1);
    chk("sub_data", dout, 32'hFFFF_FFFF);
    valid = 1'b0;
    tick();
    chk("pulse_width", 32'(vout), 32'd0);
    chk("hold_data", dout, 32'hFFFF_FFFF);

    // MUL 7 x 6: 32 stall cycles, single valid pulse
    run_mul(32'd7, 32'd6);
    chk("mul1_stall_cycles", 32'(n), 32'd32);
    chk("mul1_early_valid", 32'(nv), 32'd0);
    chk("mul1_valid", 32'(vout), 32'd1);
    chk("mul1_data", dout, 32'd42);
    chk("mul1_ready", 32'(ready), 32'd1);
    tick();
    chk("mul1_pulse_end", 32'(vout), 32'd0);

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul2_valid", 32'(vout), 32'd1);
    chk("mul2_data", dout, 32'h1);
    chk("mul2_zero", 32'(zero), 32'd0);

    // Shifts and logic, back to back
    op(3'b111, 32'h8000_0000, 32'd4);
    tick();
    chk("sra_data", dout, 32'hF800_0000);
    op(3'b110, 32'h1, 32'd31);
    tick();
    chk("sll_data", dout, 32'h8000_0000);
    op(3'b100, 32'h0000_F0F0, 32'h0000_0F0F);
    tick();
    chk("and_data", dout, 32'h0);
    chk("and_zero", 32'(zero), 32'd1);
    op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    chk("nop_valid", 32'(vout), 32'd1);
    chk("nop_data", dout, 32'h0);
    chk("nop_zero", 32'(zero), 32'd1);
    op(3'b101, 32'h0000_00FF, 32'h0000_000F);
    tick();
    chk("xor_data", dout, 32'h0000_00F0);
    chk("xor_zero", 32'(zero), 32'd0);
    valid = 1'b0;

    // Flush 10 cycles into MUL 3 x 5
    op(3'b010, 32'd3, 32'd5);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", 32'(ready), 32'd1);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_valid", 32'(vout), 32'd0);
    chk("flush_data", dout, 32'h0000_00F0);
    op(3'b000, 32'd2, 32'd2);
    tick();
    chk("post_flush_add", dout, 32'd4);
    chk("post_flush_valid", 32'(vout), 32'd1);

    // Flush while idle blocks the accept
    op(3'b000, 32'd9, 32'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    chk("idle_flush_valid", 32'(vout), 32'd0);
    chk("idle_flush_data", dout, 32'd4);

    // Reset mid-MUL
    op(3'b010, 32'd3, 32'd5);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_ready", 32'(ready), 32'd1);
    chk("mrst_stall", 32'(stall), 32'd0);
    chk("mrst_valid", 32'(vout), 32'd0);
    chk("mrst_data", dout, 32'h0);
    chk("mrst_zero", 32'(zero), 32'd0);
    op(3'b000, 32'd1, 32'd1);
    tick();
    chk("mrst_add_valid", 32'(vout), 32'd1);
    chk("mrst_add_data", dout, 32'd2);
    valid = 1'b0;

    // Flush on the final MUL edge discards the result
    op(3'b010, 32'd3, 32'd5);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    chk("final_pre_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("final_flush_valid", 32'(vout), 32'd0);
    chk("final_flush_data", dout, 32'd2);
    chk("final_flush_ready", 32'(ready), 32'd1);

    // MUL then ADD accepted in the valid_o cycle
    run_mul(32'd2, 32'd3);
    chk("mul_b2b_valid", 32'(vout), 32'd1);
    chk("mul_b2b_data", dout, 32'd6);
    op(3'b000, 32'd1, 32'd1);
    tick();
    valid = 1'b0;
    chk("add_b2b_valid", 32'(vout), 32'd1);
    chk("add_b2b_data", dout, 32'd2);

    // MUL_STEP=4 instance: 8-cycle latency
    valid4 = 1'b1; ctrl4 = 3'b010; d14 = 32'd2; d24 = 32'd3;
    tick();
    valid4 = 1'b0;
    n = 0;
    while (stall4 && n < 100) begin
      n++;
      tick();
    end
    chk("m4_stall_cycles", 32'(n), 32'd8);
    chk("m4_valid", 32'(vout4), 32'd1);
    chk("m4_data", dout4, 32'd6);
    valid4 = 1'b1; ctrl4 = 3'b000; d14 = 32'd1; d24 = 32'd1;
    tick();
    chk("m4_add_valid", 32'(vout4), 32'd1);
    chk("m4_add_data", dout4, 32'd2);
    valid4 = 1'b1; ctrl4 = 3'b010; d14 = 32'hFFFF_FFFF; d24 = 32'hFFFF_FFFF;
    tick();
    valid4 = 1'b0;
    n = 0;
    while (stall4 && n < 100) begin
      n++;
      tick();
    end
    chk("m4_sq_cycles", 32'(n), 32'd8);
    chk("m4_sq_data", dout4, 32'h1);
    chk("m4_sq_valid", 32'(vout4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
